// File: rtl/m_lsu_wbuf_if.sv
`default_nettype none
// ============================================================================
// Module      : m_lsu_wbuf_if
// Description : req/ack data-bus bundle between the M-stage LSU and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface m_lsu_wbuf_if #(
  parameter int ADDR_W = 32
) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_byteen;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface
`default_nettype wire

// File: rtl/m_lsu_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : m_lsu_wbuf
// Description : M-stage load/store unit with posted write buffer and req/ack
//               bus. Optional store merging into the tail: WBUF_MERGE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module m_lsu_wbuf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              Op_valid,
  input  logic              Op_ld,
  input  logic              Op_st,
  input  logic [1:0]        Size,
  input  logic              Sign,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WData,
  output logic              Stall,
  output logic [31:0]       RData,
  output logic              ExcAdEL,
  output logic              ExcAdES,
  output logic              Buf_empty,
  m_lsu_wbuf_if.master      bus
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_WA_W  = ADDR_W - 2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;
  state_t r_state, w_state_nxt;

  logic [c_WA_W-1:0]  r_addr [DEPTH];
  logic [3:0]         r_be   [DEPTH];
  logic [31:0]        r_data [DEPTH];
  logic [DEPTH-1:0]   r_vld;
  logic [c_PTR_W-1:0] r_head, r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic               r_rd_done, r_rd_kill;
  logic [31:0]        r_rdata;
  logic [c_WA_W-1:0]  r_rd_addr;
  logic [3:0]         r_rd_be;

  logic [c_WA_W-1:0]  w_word;
  logic [c_PTR_W-1:0] w_last;
  logic               w_mis, w_act, w_ld, w_st, w_hit, w_pop, w_full;
  logic               w_merge, w_push, w_rd_go;
  logic [3:0]         w_be;
  logic [31:0]        w_wdat, w_shift, w_ext;
  logic               w_req, w_we;
  logic [ADDR_W-1:0]  w_baddr;
  logic [3:0]         w_bbe;
  logic [31:0]        w_bwd;

  assign w_word = Addr[ADDR_W-1:2];
  assign w_mis  = ((Size == 2'd1) && Addr[0]) || (Size[1] && (Addr[1:0] != 2'b00));
  assign w_act  = Op_valid & ~Flush & ~Rst;
  assign w_ld   = w_act & Op_ld & ~w_mis;
  assign w_st   = w_act & Op_st & ~w_mis;

  assign ExcAdEL = w_act & Op_ld & w_mis;
  assign ExcAdES = w_act & Op_st & w_mis;

  always_comb begin
    w_be   = 4'b1111;
    w_wdat = WData;
    case (Size)
      2'd0: begin
        w_be   = 4'b0001 << Addr[1:0];
        w_wdat = {4{WData[7:0]}};
      end
      2'd1: begin
        w_be   = Addr[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{WData[15:0]}};
      end
      default: ;
    endcase
  end

  // Aligned accesses only: shifting by the byte offset lines the datum up at bit 0.
  always_comb begin
    w_shift = bus.bus_rdata >> {Addr[1:0], 3'b000};
    w_ext   = w_shift;
    case (Size)
      2'd0:    w_ext = {{24{Sign & w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_ext = {{16{Sign & w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_addr[i] == w_word)) w_hit = 1'b1;
    end
  end

  assign w_pop  = (r_state == S_WR) & bus.bus_ack;
  assign w_full = (r_count == c_CNT_W'(DEPTH));
  assign w_last = r_tail - c_PTR_W'(1);

`ifdef WBUF_MERGE_EN
  // The head being written on the bus must not change under the transaction.
  assign w_merge = w_st && r_vld[w_last] && (r_addr[w_last] == w_word) &&
                   !((r_state == S_WR) && (w_last == r_head));
`else
  assign w_merge = 1'b0;
`endif

  assign w_push  = w_st & ~w_merge & (~w_full | w_pop);
  assign w_rd_go = w_ld & ~w_hit & ~r_rd_done;

  assign Stall     = (w_st & ~w_merge & w_full & ~w_pop) | (w_ld & ~r_rd_done);
  assign Buf_empty = (r_count == '0) | Rst;
  assign RData     = r_rdata;

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_we        = 1'b0;
    w_baddr     = '0;
    w_bbe       = 4'b0000;
    w_bwd       = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_rd_go)              w_state_nxt = S_RD;
        else if (r_count != '0)   w_state_nxt = S_WR;
      end
      S_RD: begin
        w_req   = 1'b1;
        w_baddr = {r_rd_addr, 2'b00};
        w_bbe   = r_rd_be;
        if (bus.bus_ack) w_state_nxt = S_IDLE;
      end
      S_WR: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_baddr = {r_addr[r_head], 2'b00};
        w_bbe   = r_be[r_head];
        w_bwd   = r_data[r_head];
        if (bus.bus_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.bus_req    = w_req & ~Rst;
  assign bus.bus_we     = w_we;
  assign bus.bus_addr   = w_baddr;
  assign bus.bus_byteen = w_bbe;
  assign bus.bus_wdata  = w_bwd;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_vld     <= '0;
      r_rd_done <= 1'b0;
      r_rd_kill <= 1'b0;
      r_rdata   <= 32'd0;
      r_rd_addr <= '0;
      r_rd_be   <= 4'b0000;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_be[i]   <= 4'b0000;
        r_data[i] <= 32'd0;
      end
    end else begin
      // Pop before push so a same-edge refill of a full buffer keeps its valid bit.
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + c_PTR_W'(1);
      end
      if (w_push) begin
        r_vld[r_tail]  <= 1'b1;
        r_addr[r_tail] <= w_word;
        r_be[r_tail]   <= w_be;
        r_data[r_tail] <= w_wdat;
        r_tail         <= r_tail + c_PTR_W'(1);
      end
      if (w_merge) begin
        r_be[w_last] <= r_be[w_last] | w_be;
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_data[w_last][8*b +: 8] <= w_wdat[8*b +: 8];
        end
      end
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

      if ((r_state == S_IDLE) && (w_state_nxt == S_RD)) begin
        r_rd_addr <= w_word;
        r_rd_be   <= w_be;
      end

      if (r_state == S_RD) begin
        if (bus.bus_ack)  r_rd_kill <= 1'b0;
        else if (Flush)   r_rd_kill <= 1'b1;
      end

      if ((r_state == S_RD) && bus.bus_ack && !r_rd_kill && !Flush) begin
        r_rd_done <= 1'b1;
        r_rdata   <= w_ext;
      end else if (Flush || (Op_valid && !Stall)) begin
        r_rd_done <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_m_lsu_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_lsu_wbuf
// Description : Scoreboard bench for m_lsu_wbuf with a memory-model bus slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_lsu_wbuf;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst, flush, op_valid, op_ld, op_st, sign;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        stall, exc_adel, exc_ades, buf_empty;
  logic [31:0] rdata;

  m_lsu_wbuf_if #(.ADDR_W(ADDR_W)) bus ();

  m_lsu_wbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clk(clk), .Rst(rst), .Flush(flush), .Op_valid(op_valid), .Op_ld(op_ld),
    .Op_st(op_st), .Size(size), .Sign(sign), .Addr(addr), .WData(wdata),
    .Stall(stall), .RData(rdata), .ExcAdEL(exc_adel), .ExcAdES(exc_ades),
    .Buf_empty(buf_empty), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] slv_mem [256];
  wr_t         wq[$];
  logic [31:0] rq[$];

  bit          hold = 1'b0;
  int          credits = 0;
  int          ack_dly = 1;
  bit          dly_rand = 1'b0;
  int          wr_count = 0;
  logic [31:0] last_a, last_wd;
  logic [3:0]  last_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int  n    = nbytes(sz);
    int  base = int'(a % 4);
    wr_t e;
    e.a  = {a[31:2], 2'b00};
    e.be = 4'b0000;
    for (int k = 0; k < n; k++) begin
      ref_mem[a[9:2]][8*(base+k) +: 8] = d[8*k +: 8];
      e.be[base+k] = 1'b1;
    end
    for (int l = 0; l < 4; l++) e.d[8*l +: 8] = d[8*(l % n) +: 8];
    wq.push_back(e);
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int          n    = nbytes(sz);
    int          base = int'(a % 4);
    logic [31:0] v    = 32'd0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[a[9:2]][8*(base+k) +: 8];
    if (sg && (n < 4) && v[8*n-1]) begin
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  // ---------------- bus slave + write monitor ----------------
  initial begin : slave
    logic [68:0] cur, saved;
    int          cnt;
    bit          waiting;
    cnt = 0; waiting = 1'b0; saved = '0;
    bus.bus_ack = 1'b0;
    bus.bus_rdata = 32'd0;
    for (int i = 0; i < 256; i++) slv_mem[i] = 32'd0;
    forever begin
      @(negedge clk);
      cur = {bus.bus_addr, bus.bus_we, bus.bus_byteen, bus.bus_wdata};
      if (rst || bus.bus_ack) begin
        bus.bus_ack = 1'b0;
        cnt = 0;
        waiting = 1'b0;
      end else if (bus.bus_req) begin
        if (waiting) check("bus_stable", {31'd0, cur === saved}, 32'd1);
        saved = cur;
        waiting = 1'b1;
        cnt++;
        if ((cnt >= ack_dly) && (!hold || credits > 0)) begin
          if (hold) credits--;
          bus.bus_ack = 1'b1;
          waiting = 1'b0;
          if (dly_rand) ack_dly = $urandom_range(1, 3);
          if (bus.bus_we) begin
            for (int b = 0; b < 4; b++)
              if (bus.bus_byteen[b]) slv_mem[bus.bus_addr[9:2]][8*b +: 8] = bus.bus_wdata[8*b +: 8];
            wr_count++;
            last_a  = bus.bus_addr;
            last_be = bus.bus_byteen;
            last_wd = bus.bus_wdata;
`ifndef WBUF_MERGE_EN
            if (wq.size() == 0) begin
              check("wr_unexpected", {31'd0, 1'b1}, 32'd0);
            end else begin
              wr_t e;
              e = wq.pop_front();
              check("wr_addr", bus.bus_addr, e.a);
              check("wr_byteen", {28'd0, bus.bus_byteen}, {28'd0, e.be});
              check("wr_data", bus.bus_wdata, e.d);
            end
`endif
          end else begin
            bus.bus_rdata = slv_mem[bus.bus_addr[9:2]];
          end
        end
      end
    end
  end

  // ---------------- load-result monitor ----------------
  initial begin : rd_monitor
    forever begin
      @(negedge clk);
      #1;
      if (!rst && op_valid && op_ld && !op_st && !flush && !stall && !exc_adel) begin
        if (rq.size() == 0) check("rd_unexpected", rdata, 32'hxxxxxxxx);
        else                check("rdata", rdata, rq.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit ld, input bit st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d, input string tag,
                       output int ns);
    bit mis;
    mis = misal(sz, a);
    ns = 0;
    @(posedge clk); #1;
    op_valid = 1'b1; op_ld = ld; op_st = st; size = sz; sign = sg; addr = a; wdata = d;
    #1;
    check({tag, "_adel"}, {31'd0, exc_adel}, {31'd0, ld & mis});
    check({tag, "_ades"}, {31'd0, exc_ades}, {31'd0, st & mis});
    if (mis)     check({tag, "_fault_stall"}, {31'd0, stall}, 32'd0);
    else if (st) model_store(sz, a, d);
    else if (ld) rq.push_back(model_load(sz, sg, a));
    for (int i = 0; ; i++) begin
      @(negedge clk); #1;
      if (!stall) break;
      ns++;
      if (i > 300) begin
        check({tag, "_stall_timeout"}, {31'd0, stall}, 32'd0);
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    op_valid = 1'b0; op_ld = 1'b0; op_st = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (buf_empty && !bus.bus_req) break;
    end
    check({tag, "_drained"}, {31'd0, buf_empty & ~bus.bus_req}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int          ns, base_wr;
    bit          r_ld;
    logic [1:0]  r_sz;
    logic [31:0] r_a;

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    rst = 1'b1; flush = 1'b0; op_valid = 1'b1; op_ld = 1'b1; op_st = 1'b0;
    size = 2'd2; sign = 1'b0; addr = 32'h100; wdata = 32'd0;

    // Reset: a pending load miss and a misaligned load must both stay silent.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_bus_req", {31'd0, bus.bus_req}, 32'd0);
    check("rst_buf_empty", {31'd0, buf_empty}, 32'd1);
    addr = 32'h102;
    #1;
    check("rst_adel", {31'd0, exc_adel}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; op_valid = 1'b0; op_ld = 1'b0;

    // Single word store with a one-cycle ack.
    base_wr = wr_count;
    issue(0, 1, 2'd2, 0, 32'h100, 32'h12345678, "sw", ns);
    check("sw_no_stall", ns, 0);
    idle();
    wait_empty("sw");
    check("sw_wr_count", wr_count - base_wr, 1);
    check("sw_addr", last_a, 32'h100);
    check("sw_be", {28'd0, last_be}, 32'hF);
    check("sw_data", last_wd, 32'h12345678);

    // Fill the buffer with the bus blocked, then free exactly one slot.
    hold = 1'b1; credits = 0;
    base_wr = wr_count;
    for (int i = 0; i < DEPTH; i++) begin
      issue(0, 1, 2'd2, 0, 32'h140 + 32'(4*i), 32'hA000_0000 + 32'(i), "fill", ns);
      check("fill_no_stall", ns, 0);
    end
    @(posedge clk); #1;
    op_valid = 1'b1; op_ld = 1'b0; op_st = 1'b1; size = 2'd2; addr = 32'h150; wdata = 32'hA5A5_0005;
    model_store(2'd2, 32'h150, 32'hA5A5_0005);
    #1;
    check("full_stall", {31'd0, stall}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("full_stall_held", {31'd0, stall}, 32'd1);
    credits = 1;
    @(negedge clk); #1;
    check("full_ack_frees", {31'd0, stall}, 32'd0);
    idle();
    check("full_not_empty", {31'd0, buf_empty}, 32'd0);
    hold = 1'b0;
    wait_empty("full");
    check("full_wr_count", wr_count - base_wr, DEPTH + 1);

    // Byte store then dependent byte loads, slow bus.
    ack_dly = 3;
    issue(0, 1, 2'd0, 0, 32'h203, 32'h0000_00AB, "sb", ns);
    issue(1, 0, 2'd0, 1, 32'h203, 32'h0, "lb", ns);
    check("lb_value", rdata, 32'hFFFF_FFAB);
    check("lb_slave_word", slv_mem[8'h80], 32'hAB00_0000);
    issue(1, 0, 2'd0, 0, 32'h203, 32'h0, "lbu", ns);
    check("lbu_value", rdata, 32'h0000_00AB);
    idle();
    wait_empty("lb");

    // Alignment boundaries; aligned miss load costs exactly two stall cycles.
    ack_dly = 1;
    issue(1, 0, 2'd1, 0, 32'h102, 32'h0, "lh", ns);
    check("lh_min_stall", ns, 2);
    issue(1, 0, 2'd2, 0, 32'h102, 32'h0, "lw_mis", ns);
    check("lw_mis_no_req", {31'd0, bus.bus_req}, 32'd0);
    issue(0, 1, 2'd1, 0, 32'h101, 32'hBEEF, "sh_mis", ns);
    check("sh_mis_empty", {31'd0, buf_empty}, 32'd1);
    idle();

    // Flush while a read is outstanding; buffered stores must still drain.
    issue(0, 1, 2'd2, 0, 32'h110, 32'h1111_1111, "pre0", ns);
    issue(0, 1, 2'd2, 0, 32'h114, 32'h2222_2222, "pre1", ns);
    idle();
    wait_empty("pre");
    hold = 1'b1; credits = 0;
    issue(0, 1, 2'd2, 0, 32'h120, 32'hC0DE_0001, "fl_st0", ns);
    issue(0, 1, 2'd2, 0, 32'h124, 32'hC0DE_0002, "fl_st1", ns);
    @(posedge clk); #1;
    op_valid = 1'b1; op_ld = 1'b1; op_st = 1'b0; size = 2'd2; sign = 1'b0; addr = 32'h110;
    credits = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (bus.bus_req && !bus.bus_we) break;
    end
    check("fl_read_issued", {31'd0, bus.bus_req & ~bus.bus_we}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    check("fl_stall_during_flush", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op_ld = 1'b0;
    hold = 1'b0;
    issue(1, 0, 2'd2, 0, 32'h114, 32'h0, "fl_next_lw", ns);
    check("fl_next_value", rdata, 32'h2222_2222);
    check("fl_next_stalled", {31'd0, ns >= 2}, 32'd1);
    idle();
    wait_empty("fl");

    // Two byte stores to the same word behind a blocked head.
    hold = 1'b1; credits = 0;
    base_wr = wr_count;
    issue(0, 1, 2'd2, 0, 32'h380, 32'h5555_5555, "mg_head", ns);
    issue(0, 1, 2'd0, 0, 32'h300, 32'h11, "mg_sb0", ns);
    issue(0, 1, 2'd0, 0, 32'h301, 32'h22, "mg_sb1", ns);
    idle();
    hold = 1'b0;
    wait_empty("mg");
`ifdef WBUF_MERGE_EN
    check("mg_wr_count", wr_count - base_wr, 2);
    check("mg_be", {28'd0, last_be}, 32'h3);
    check("mg_data", {16'd0, last_wd[15:0]}, 32'h2211);
`else
    check("mg_wr_count", wr_count - base_wr, 3);
    check("mg_be", {28'd0, last_be}, 32'h2);
`endif
    check("mg_addr", last_a, 32'h300);

    // Randomised mix over a small window so loads frequently hit the buffer.
    dly_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r_ld = 1'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 3));
      r_a  = 32'h100 + 32'($urandom_range(0, 31));
      issue(r_ld, !r_ld, r_sz, 1'($urandom_range(0, 1)), r_a, $urandom, "rnd", ns);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    wait_empty("rnd");
    repeat (4) @(negedge clk);

    for (int i = 0; i < 256; i++) check("mem_image", slv_mem[i], ref_mem[i]);
    check("rq_empty", rq.size(), 0);
`ifndef WBUF_MERGE_EN
    check("wq_empty", wq.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
